simon_seq_engine: RTL and testbench

//  Consumer end of the LFSR random-bit interface: drives step/rerun, assembles 2-bit colours from random.

---
 rtl/simon_pkg.sv | 41 ++++
 rtl/simon_tick_timer.sv | 38 +++
 rtl/simon_seq_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_simon_seq_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types for the Simon sequence engine.
//   color_t : 2-bit colour code (RED=0, GRN=1, BLU=2, YEL=3)
//   state_t : sequencer FSM states
//   phase_t : SHOW while replaying to the player, CHECK while verifying presses
//   tick_width() : counter width able to hold the largest of three tick counts
package simon_pkg;

    typedef enum logic [1:0] {
        RED = 2'd0,
        GRN = 2'd1,
        BLU = 2'd2,
        YEL = 2'd3
    } color_t;

    typedef enum logic [3:0] {
        IDLE,
        RERUN,
        FETCH_LO,
        FETCH_HI,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        ROUND_GAP,
        WIN,
        FAIL
    } state_t;

    typedef enum logic {
        SHOW,
        CHECK
    } phase_t;

    function automatic int tick_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/simon_tick_timer.sv
// Loadable down-counter used for LED on/off timing and the input timeout.
//   clk, reset : clock, synchronous active-high reset (count cleared)
//   load       : load value into the counter this cycle
//   value      : count to load; done rises after value further cycles
//   done       : counter is at zero
module simon_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/simon_seq_engine.sv
// Simon sequence engine: drives the LFSR (step/rerun), builds 2-bit colours from
// its random bit, plays the sequence on the LED and checks the player's presses.
// The sequence is regenerated each pass by reloading the LFSR seed, so no RAM.
//   clk, reset      : clock, synchronous active-high reset
//   start           : begin a new game (ignored while busy)
//   random          : LFSR output bit
//   step, rerun     : advance / reload the LFSR on the next clock
//   btn_valid/color : debounced press and its colour
//   led_on/color    : LED drive
//   round           : current sequence length (0 in IDLE)
//   busy, awaiting_input, win, fail : status
// Optional feature macro: SIMON_INPUT_TIMEOUT_EN (fail on no press within
// TIMEOUT_TICKS cycles in WAIT_IN).
module simon_seq_engine
    import simon_pkg::*;
#(
    parameter int MAX_ROUND     = 16,
    parameter int ON_TICKS      = 12_500_000,
    parameter int GAP_TICKS     = 6_250_000,
    parameter int TIMEOUT_TICKS = 50_000_000,
    localparam int RW           = $clog2(MAX_ROUND + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          random,
    output logic          step,
    output logic          rerun,
    input  logic          btn_valid,
    input  logic [1:0]    btn_color,
    output logic          led_on,
    output logic [1:0]    led_color,
    output logic [RW-1:0] round,
    output logic          busy,
    output logic          awaiting_input,
    output logic          win,
    output logic          fail
);

    localparam int TW = tick_width(ON_TICKS, GAP_TICKS, TIMEOUT_TICKS);

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [RW-1:0] idx_q, idx_d;
    logic [RW-1:0] round_q, round_d;
    logic          win_q, win_d;
    logic          fail_q, fail_d;
    logic          step_q, step_d;
    logic          rerun_q, rerun_d;
    logic          led_on_q, led_on_d;
    color_t        led_color_q, led_color_d;
    logic          busy_q, busy_d;
    logic          await_q, await_d;
    logic          b0_q, b0_d;
    color_t        color_q, color_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic          timeout_hit;

    simon_tick_timer #(.W(TW)) u_tick (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

`ifdef SIMON_INPUT_TIMEOUT_EN
    logic to_load;
    logic to_done;

    // Loaded with TIMEOUT_TICKS-1 so WAIT_IN lasts exactly TIMEOUT_TICKS idle cycles.
    simon_tick_timer #(.W(TW)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .load  (to_load),
        .value (TW'(TIMEOUT_TICKS - 1)),
        .done  (to_done)
    );
    assign timeout_hit = to_done;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        round_d  = round_q;
        win_d    = win_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef SIMON_INPUT_TIMEOUT_EN
        to_load  = 1'b0;
`endif
        // Colour assembly: low bit captured in FETCH_LO, high bit in FETCH_HI.
        b0_d     = (state_q == FETCH_LO) ? random : b0_q;
        color_d  = (state_q == FETCH_HI) ? color_t'({random, b0_q}) : color_q;

        case (state_q)
            IDLE, WIN, FAIL: begin
                if (start) begin
                    round_d = RW'(1);
                    win_d   = 1'b0;
                    fail_d  = 1'b0;
                    phase_d = SHOW;
                    state_d = RERUN;
                end
            end
            RERUN: begin
                idx_d   = '0;
                state_d = FETCH_LO;
            end
            FETCH_LO: state_d = FETCH_HI;
            FETCH_HI: begin
                if (phase_q == SHOW) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ON_TICKS - 1);
                    state_d  = SHOW_ON;
                end else begin
`ifdef SIMON_INPUT_TIMEOUT_EN
                    to_load  = 1'b1;
`endif
                    state_d  = WAIT_IN;
                end
            end
            SHOW_ON: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_TICKS - 1);
                    state_d  = SHOW_OFF;
                end
            end
            SHOW_OFF: begin
                if (tmr_done) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_d == round_q) begin
                        phase_d = CHECK;
                        state_d = RERUN;
                    end else begin
                        state_d = FETCH_LO;
                    end
                end
            end
            WAIT_IN: begin
                // A press takes priority over a simultaneous timeout expiry.
                if (btn_valid) begin
                    if (btn_color == color_q) begin
                        idx_d = idx_q + 1'b1;
                        if (idx_d == round_q) begin
                            if (round_q == RW'(MAX_ROUND)) begin
                                win_d   = 1'b1;
                                state_d = WIN;
                            end else begin
                                tmr_load = 1'b1;
                                tmr_val  = TW'(GAP_TICKS - 1);
                                state_d  = ROUND_GAP;
                            end
                        end else begin
                            state_d = FETCH_LO;
                        end
                    end else begin
                        fail_d  = 1'b1;
                        state_d = FAIL;
                    end
                end else if (timeout_hit) begin
                    fail_d  = 1'b1;
                    state_d = FAIL;
                end
            end
            ROUND_GAP: begin
                if (tmr_done) begin
                    round_d = round_q + 1'b1;
                    phase_d = SHOW;
                    state_d = RERUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with state_q.
        step_d      = (state_d == FETCH_LO) || (state_d == FETCH_HI);
        rerun_d     = (state_d == RERUN);
        led_on_d    = (state_d == SHOW_ON);
        led_color_d = led_on_d ? color_d : RED;
        busy_d      = !((state_d == IDLE) || (state_d == WIN) || (state_d == FAIL));
        await_d     = (state_d == WAIT_IN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= SHOW;
            idx_q       <= '0;
            round_q     <= '0;
            win_q       <= 1'b0;
            fail_q      <= 1'b0;
            step_q      <= 1'b0;
            rerun_q     <= 1'b0;
            led_on_q    <= 1'b0;
            led_color_q <= RED;
            busy_q      <= 1'b0;
            await_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            round_q     <= round_d;
            win_q       <= win_d;
            fail_q      <= fail_d;
            step_q      <= step_d;
            rerun_q     <= rerun_d;
            led_on_q    <= led_on_d;
            led_color_q <= led_color_d;
            busy_q      <= busy_d;
            await_q     <= await_d;
        end
    end

    // Colour datapath needs no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        b0_q    <= b0_d;
        color_q <= color_d;
    end

    assign step           = step_q;
    assign rerun          = rerun_q;
    assign led_on         = led_on_q;
    assign led_color      = led_color_q;
    assign round          = round_q;
    assign busy           = busy_q;
    assign awaiting_input = await_q;
    assign win            = win_q;
    assign fail           = fail_q;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Bench for simon_seq_engine with a 16-bit Fibonacci LFSR model seeded 16'hACE1.
// Expected colours are the seed's low bits taken in pairs: 1, 0, 2.
module tb_simon_seq_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       random;
    logic       step;
    logic       rerun;
    logic       btn_valid;
    logic [1:0] btn_color;
    logic       led_on;
    logic [1:0] led_color;
    logic [1:0] round;
    logic       busy;
    logic       awaiting_input;
    logic       win;
    logic       fail;

    logic [15:0] lfsr;
    int          checks;
    int          failures;
    int          exp_q[$];
    bit          mon_en;
    bit          prev_on;
    int          on_len;

    simon_seq_engine #(
        .MAX_ROUND     (3),
        .ON_TICKS      (4),
        .GAP_TICKS     (2),
        .TIMEOUT_TICKS (20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .random         (random),
        .step           (step),
        .rerun          (rerun),
        .btn_valid      (btn_valid),
        .btn_color      (btn_color),
        .led_on         (led_on),
        .led_color      (led_color),
        .round          (round),
        .busy           (busy),
        .awaiting_input (awaiting_input),
        .win            (win),
        .fail           (fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (reset || rerun) lfsr <= 16'hACE1;
        else if (step)      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    assign random = lfsr[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each LED flash pops the next expected colour and must last 4 cycles.
    always @(negedge clk) begin
        int e;
        if (led_on && !prev_on) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("led_color", {30'd0, led_color}, e);
            on_len = 1;
        end else if (led_on) begin
            on_len++;
        end else if (prev_on && mon_en) begin
            chk("led_on_len", on_len, 4);
        end
        prev_on = led_on;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        @(negedge clk);
        btn_valid = 1'b0;
        btn_color = 2'd0;
    endtask

    task automatic wait_await(input string tag);
        int n;
        n = 0;
        while (awaiting_input !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, awaiting_input}, 1);
    endtask

    task automatic wait_led(input string tag);
        int n;
        n = 0;
        while (led_on !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, led_on}, 1);
    endtask

    function automatic logic [10:0] outs();
        return {step, rerun, led_on, led_color, round, busy, awaiting_input, win, fail};
    endfunction

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        mon_en    = 1'b1;
        prev_on   = 1'b0;
        on_len    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        btn_valid = 1'b0;
        btn_color = 2'd0;
        cycles(3);
        chk("reset_outputs", {21'd0, outs()}, 0);
        reset = 1'b0;
        cycles(1);
        chk("idle_outputs", {21'd0, outs()}, 0);

        // Round 1: rerun, two steps, then colour 1 for four cycles.
        exp_q.push_back(1);
        do_start();
        chk("rerun_pulse", {30'd0, rerun, step}, 32'h2);
        chk("round_after_start", {30'd0, round}, 1);
        cycles(1);
        chk("step_lo", {30'd0, rerun, step}, 32'h1);
        cycles(1);
        chk("step_hi", {30'd0, rerun, step}, 32'h1);
        cycles(1);
        chk("first_led", {29'd0, step, led_on, busy}, 32'h3);
        wait_await("await_r1");
        chk("round_r1", {30'd0, round}, 1);

        // Correct press -> round gap -> round 2 shows 1, 0.
        exp_q.push_back(1);
        exp_q.push_back(0);
        press(2'd1);
        chk("gap_state", {28'd0, round, led_on, awaiting_input}, 32'h4);
        cycles(1);
        chk("gap_round_hold", {30'd0, round}, 1);
        cycles(1);
        chk("round2_rerun", {29'd0, round, rerun}, 32'h5);
        wait_await("await_r2");

        // Round 2: correct then wrong press -> fail.
        press(2'd1);
        wait_await("await_r2_e1");
        press(2'd2);
        chk("fail_flags", {28'd0, fail, busy, led_on, awaiting_input}, 32'h8);
        chk("fail_round_hold", {30'd0, round}, 2);

        // Restart clears fail and replays colour 1.
        exp_q.push_back(1);
        do_start();
        chk("restart_clear", {29'd0, fail, round}, 32'h1);
        wait_await("await_restart");

        // Win path, with a stray press during SHOW_ON that must be ignored.
        exp_q.push_back(1);
        exp_q.push_back(0);
        press(2'd1);
        wait_led("led_r2");
        press(2'd3);
        wait_await("await_after_stray");
        chk("stray_no_fail", {31'd0, fail}, 0);
        press(2'd1);
        wait_await("await_r2b");
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(2);
        press(2'd0);
        wait_await("await_r3");
        chk("round_r3", {30'd0, round}, 3);
        press(2'd1);
        wait_await("await_r3_e1");
        press(2'd0);
        wait_await("await_r3_e2");
        press(2'd2);
        chk("win_flags", {28'd0, win, fail, busy, awaiting_input}, 32'h8);
        chk("win_round", {30'd0, round}, 3);

        // Reset during SHOW_ON aborts with all outputs low and no pulses.
        exp_q.push_back(1);
        do_start();
        wait_led("led_before_reset");
        mon_en = 1'b0;
        reset  = 1'b1;
        cycles(1);
        chk("reset_midgame", {21'd0, outs()}, 0);
        cycles(1);
        chk("reset_hold", {21'd0, outs()}, 0);
        reset = 1'b0;
        cycles(2);
        chk("post_reset_idle", {21'd0, outs()}, 0);
        mon_en = 1'b1;

        // Idle in WAIT_IN.
        exp_q.push_back(1);
        do_start();
        wait_await("await_idle_test");
`ifdef SIMON_INPUT_TIMEOUT_EN
        n = 0;
        while (fail !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_fail", {31'd0, fail}, 1);
        chk("timeout_cycles", n, 20);
`else
        cycles(100);
        n = 0;
        chk("no_timeout_await", {31'd0, awaiting_input}, 1);
        chk("no_timeout_fail", {31'd0, fail}, 0);
`endif
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
